pc_branch_unit: RTL and testbench

Downstream consumer of the branch comparator in the single-cycle RV32I core.
- Takes the signed less, unsigned less and equal flags together with decode controls.
- Resolves the branch or jump, computes the next PC and holds the architectural PC register.
- Detects misaligned control-transfer targets and halts the core until it is resumed.
- Keeps retired-instruction and taken-redirect counters.

---
 rtl/pc_branch_unit.sv | 157 +++++++++++++++
 tb/tb_pc_branch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Branch/jump resolution, next-PC selection and architectural PC register for the
// single-cycle RV32I core, with misaligned-target halt and retire/redirect counters.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        br_less,
  input  logic        br_lessu,
  input  logic        br_equal,
  input  logic        stall,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic [31:0] next_pc,
  output logic        br_taken,
  output logic        illegal_br,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] instret,
  output logic [31:0] taken_cnt
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_r, state_nx_s;
  logic [31:0] pc_r, pc_nx_s;
  logic        trap_r, trap_nx_s;
  logic [31:0] trap_addr_r, trap_addr_nx_s;
  logic [31:0] instret_r, instret_nx_s;
  logic [31:0] taken_cnt_r, taken_cnt_nx_s;

  logic        cond_s;
  logic        illegal_s;
  logic [31:0] pc_four_s;
  logic [31:0] target_s;
  logic        br_taken_s;
  logic [31:0] next_pc_s;
  logic        misalign_s;

  // Branch condition decode from the comparator flags.
  always_comb begin
    cond_s    = 1'b0;
    illegal_s = 1'b0;
    if (is_branch) begin
      case (funct3)
        3'b000:  cond_s = br_equal;
        3'b001:  cond_s = !br_equal;
        3'b100:  cond_s = br_less;
        3'b101:  cond_s = !br_less;
        3'b110:  cond_s = br_lessu;
        3'b111:  cond_s = !br_lessu;
        3'b010,
        3'b011:  illegal_s = 1'b1;
        default: cond_s = 1'b0;
      endcase
    end else begin
      cond_s    = 1'b0;
      illegal_s = 1'b0;
    end
  end

  // Target selection: JAL beats JALR beats branch; JALR clears bit 0.
  always_comb begin
    pc_four_s = pc_r + 32'd4;
    target_s  = pc_r + imm;
    if (is_jal) begin
      target_s = pc_r + imm;
    end else if (is_jalr) begin
      target_s = (rs1_data + imm) & 32'hFFFF_FFFE;
    end else begin
      target_s = pc_r + imm;
    end
    br_taken_s = is_jal | is_jalr | (is_branch & cond_s);
    next_pc_s  = br_taken_s ? target_s : pc_four_s;
    misalign_s = br_taken_s & (target_s[1:0] != 2'b00);
  end

  // Next-state and register update selection; stall outranks misalign in RUN.
  always_comb begin
    state_nx_s     = state_r;
    pc_nx_s        = pc_r;
    trap_nx_s      = trap_r;
    trap_addr_nx_s = trap_addr_r;
    instret_nx_s   = instret_r;
    taken_cnt_nx_s = taken_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (stall) begin
          state_nx_s = ST_RUN;
        end else if (misalign_s) begin
          state_nx_s     = ST_HALT;
          trap_nx_s      = 1'b1;
          trap_addr_nx_s = target_s;
        end else begin
          pc_nx_s        = next_pc_s;
          instret_nx_s   = instret_r + 32'd1;
          taken_cnt_nx_s = taken_cnt_r + {31'd0, br_taken_s};
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nx_s = ST_RUN;
          pc_nx_s    = RESET_PC;
          trap_nx_s  = 1'b0;
        end else begin
          state_nx_s = ST_HALT;
          trap_nx_s  = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        pc_nx_s    = RESET_PC;
        trap_nx_s  = 1'b0;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      trap_r      <= 1'b0;
      trap_addr_r <= 32'd0;
      instret_r   <= 32'd0;
      taken_cnt_r <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      trap_r      <= trap_nx_s;
      trap_addr_r <= trap_addr_nx_s;
      instret_r   <= instret_nx_s;
      taken_cnt_r <= taken_cnt_nx_s;
    end
  end

  assign pc         = pc_r;
  assign pc_four    = pc_four_s;
  assign next_pc    = next_pc_s;
  assign br_taken   = br_taken_s;
  assign illegal_br = illegal_s;
  assign trap       = trap_r;
  assign trap_addr  = trap_addr_r;
  assign instret    = instret_r;
  assign taken_cnt  = taken_cnt_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit with RESET_PC = 0x100.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_data;
  logic        br_less, br_lessu, br_equal;
  logic        stall, resume;
  logic [31:0] pc, pc_four, next_pc, trap_addr, instret, taken_cnt;
  logic        br_taken, illegal_br, trap;

  int checks = 0;
  int failures = 0;

  pc_branch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .funct3(funct3), .imm(imm), .rs1_data(rs1_data),
    .br_less(br_less), .br_lessu(br_lessu), .br_equal(br_equal),
    .stall(stall), .resume(resume), .pc(pc), .pc_four(pc_four),
    .next_pc(next_pc), .br_taken(br_taken), .illegal_br(illegal_br),
    .trap(trap), .trap_addr(trap_addr), .instret(instret), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; funct3 = 3'b000;
    imm = 32'd0; rs1_data = 32'd0; br_less = 1'b0; br_lessu = 1'b0;
    br_equal = 1'b0; stall = 1'b0; resume = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    idle();
    is_jalr = 1'b1; rs1_data = addr;
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_pc", pc, 32'h100);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_trap_addr", trap_addr, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_taken", taken_cnt, 32'd0);
    chk("rst_pc_four", pc_four, 32'h104);
    chk("rst_next_pc", next_pc, 32'h104);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    rst_n = 1'b1;

    // 1: sequential fetch
    tick(); chk("seq_pc1", pc, 32'h104);
    tick(); chk("seq_pc2", pc, 32'h108);
    tick(); chk("seq_pc3", pc, 32'h10C);
    chk("seq_instret", instret, 32'd3);
    chk("seq_taken", taken_cnt, 32'd0);

    // 2: BGE taken backwards, then not taken
    jump_to(32'h200);
    chk("jalr_pc", pc, 32'h200);
    chk("jalr_taken", taken_cnt, 32'd1);
    is_branch = 1'b1; funct3 = 3'b101; br_less = 1'b0; imm = 32'hFFFF_FFF0;
    #1;
    chk("bge_br_taken", {31'd0, br_taken}, 32'd1);
    chk("bge_next_pc", next_pc, 32'h1F0);
    chk("bge_illegal", {31'd0, illegal_br}, 32'd0);
    tick();
    chk("bge_pc", pc, 32'h1F0);
    chk("bge_taken_cnt", taken_cnt, 32'd2);
    chk("bge_instret", instret, 32'd5);
    jump_to(32'h200);
    is_branch = 1'b1; funct3 = 3'b101; br_less = 1'b1; imm = 32'hFFFF_FFF0;
    #1;
    chk("bge_nt_br_taken", {31'd0, br_taken}, 32'd0);
    tick();
    chk("bge_nt_pc", pc, 32'h204);
    chk("bge_nt_taken_cnt", taken_cnt, 32'd3);
    chk("bge_nt_instret", instret, 32'd7);

    // 3: misaligned JALR halts, resume returns to RESET_PC
    idle(); is_jalr = 1'b1; rs1_data = 32'h1003;
    #1;
    chk("mis_next_pc", next_pc, 32'h1002);
    tick();
    chk("mis_trap", {31'd0, trap}, 32'd1);
    chk("mis_trap_addr", trap_addr, 32'h1002);
    chk("mis_pc", pc, 32'h204);
    idle(); stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("halt_pc", pc, 32'h204);
    chk("halt_instret", instret, 32'd7);
    chk("halt_trap", {31'd0, trap}, 32'd1);
    idle(); resume = 1'b1;
    tick();
    idle();
    chk("resume_pc", pc, 32'h100);
    chk("resume_trap", {31'd0, trap}, 32'd0);
    chk("resume_trap_addr", trap_addr, 32'h1002);
    chk("resume_instret", instret, 32'd7);

    // 4: stall beats misalign; trap follows once stall drops
    is_jalr = 1'b1; rs1_data = 32'h2007; stall = 1'b1;
    tick();
    chk("stall_trap", {31'd0, trap}, 32'd0);
    chk("stall_pc", pc, 32'h100);
    chk("stall_instret", instret, 32'd7);
    stall = 1'b0;
    tick();
    chk("unstall_trap", {31'd0, trap}, 32'd1);
    chk("unstall_trap_addr", trap_addr, 32'h2006);
    idle(); resume = 1'b1;
    tick();
    idle();
    chk("resume2_pc", pc, 32'h100);

    // 5: illegal funct3 retires not-taken; PC wrap
    is_branch = 1'b1; funct3 = 3'b011; br_equal = 1'b1; imm = 32'h40;
    #1;
    chk("ill_flag", {31'd0, illegal_br}, 32'd1);
    chk("ill_br_taken", {31'd0, br_taken}, 32'd0);
    tick();
    chk("ill_pc", pc, 32'h104);
    chk("ill_instret", instret, 32'd8);
    chk("ill_taken_cnt", taken_cnt, 32'd3);
    jump_to(32'hFFFF_FFFC);
    #1;
    chk("wrap_pc_four", pc_four, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instret", instret, 32'd10);
    is_branch = 1'b1; funct3 = 3'b000; br_equal = 1'b1; imm = 32'd8;
    tick();
    chk("beq_pc", pc, 32'h8);
    idle(); is_branch = 1'b1; funct3 = 3'b110; br_lessu = 1'b1; imm = 32'hC;
    tick();
    chk("bltu_pc", pc, 32'h14);
    chk("bltu_taken_cnt", taken_cnt, 32'd6);

    // 6: JAL wins over branch; asynchronous reset between edges
    jump_to(32'h40);
    is_jal = 1'b1; is_branch = 1'b1; funct3 = 3'b000; br_equal = 1'b0; imm = 32'd8;
    #1;
    chk("pri_br_taken", {31'd0, br_taken}, 32'd1);
    chk("pri_next_pc", next_pc, 32'h48);
    tick();
    idle();
    chk("pri_pc", pc, 32'h48);
    chk("pri_instret", instret, 32'd14);
    chk("pri_taken_cnt", taken_cnt, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_instret", instret, 32'd0);
    chk("arst_taken", taken_cnt, 32'd0);
    chk("arst_trap_addr", trap_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
